// File: rtl/regfile_sb.sv
// regfile_sb: multi-ported CPU register file with busy scoreboard.
// Two write ports (ALU and load writeback) and two combinational read
// ports with optional write-to-read bypass. A busy bit per register
// is set when issue reserves it as a destination and cleared when a
// writeback lands. The reserve wins a same-cycle tie because it
// belongs to the newer producer.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              WE2,
  input  logic [ADDR_W-1:0] WA2,
  input  logic [DATA_W-1:0] WD2,
  input  logic              ResvEn,
  input  logic [ADDR_W-1:0] ResvReg,
  output logic              Busy1,
  output logic              Busy2
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;

  logic we1_ok_s;
  logic we2_ok_s;
  logic resv_ok_s;

  // Qualify writes and reserves: register 0 is hard-wired when ZERO_REG is set.
  always_comb begin
    we1_ok_s  = WE1    && !(ZERO_REG && (WA1     == ZERO_ADDR));
    we2_ok_s  = WE2    && !(ZERO_REG && (WA2     == ZERO_ADDR));
    resv_ok_s = ResvEn && !(ZERO_REG && (ResvReg == ZERO_ADDR));
  end

  // Register array: port 2 (load) overrides port 1 (ALU) on an address clash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we2_ok_s && (WA2 == ADDR_W'(i))) begin
          regs_r[i] <= WD2;
        end else if (we1_ok_s && (WA1 == ADDR_W'(i))) begin
          regs_r[i] <= WD1;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Busy scoreboard: reserve sets, writeback clears, reserve beats release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (resv_ok_s && (ResvReg == ADDR_W'(i))) begin
          busy_r[i] <= 1'b1;
        end else if ((WE1 && (WA1 == ADDR_W'(i))) || (WE2 && (WA2 == ADDR_W'(i)))) begin
          busy_r[i] <= 1'b0;
        end else begin
          busy_r[i] <= busy_r[i];
        end
      end
    end
  end

  // Read port 1: zero register, then load bypass, then ALU bypass, then array.
  always_comb begin
    RD1   = regs_r[A1];
    Busy1 = busy_r[A1];
    if (ZERO_REG && (A1 == ZERO_ADDR)) begin
      RD1   = ZERO_DATA;
      Busy1 = 1'b0;
    end else if (BYPASS && WE2 && (WA2 == A1)) begin
      RD1   = WD2;
      Busy1 = 1'b0;
    end else if (BYPASS && WE1 && (WA1 == A1)) begin
      RD1   = WD1;
      Busy1 = 1'b0;
    end else begin
      RD1   = regs_r[A1];
      Busy1 = busy_r[A1];
    end
  end

  // Read port 2: same priority as port 1 so A1 == A2 gives identical results.
  always_comb begin
    RD2   = regs_r[A2];
    Busy2 = busy_r[A2];
    if (ZERO_REG && (A2 == ZERO_ADDR)) begin
      RD2   = ZERO_DATA;
      Busy2 = 1'b0;
    end else if (BYPASS && WE2 && (WA2 == A2)) begin
      RD2   = WD2;
      Busy2 = 1'b0;
    end else if (BYPASS && WE1 && (WA1 == A2)) begin
      RD2   = WD1;
      Busy2 = 1'b0;
    end else begin
      RD2   = regs_r[A2];
      Busy2 = busy_r[A2];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, random traffic against a
// reference model, and an asynchronous reset during a write burst.
// Two instances share all inputs: one with bypass, one without.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2, wa1, wa2, rr;
  logic [31:0] wd1, wd2;
  logic        we1, we2, resv;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, busy1_nb, busy2_nb;

  int checks = 0;
  int errors = 0;

  logic [31:0] mreg  [32];
  logic        mbusy [32];

  typedef struct {
    logic        we1;  logic [4:0] wa1; logic [31:0] wd1;
    logic        we2;  logic [4:0] wa2; logic [31:0] wd2;
    logic        resv; logic [4:0] rr;
    logic [4:0]  a1;   logic [4:0] a2;
    logic [31:0] e_rd1; logic [31:0] e_rd2;
    logic        e_b1;  logic        e_b2;
    logic [31:0] e_rd1_nb; logic     e_b1_nb;
  } vec_t;

  vec_t tbl [14];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut (
    .clk(clk), .reset(reset), .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
    .WE1(we1), .WA1(wa1), .WD1(wd1), .WE2(we2), .WA2(wa2), .WD2(wd2),
    .ResvEn(resv), .ResvReg(rr), .Busy1(busy1), .Busy2(busy2));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_nb (
    .clk(clk), .reset(reset), .A1(a1), .A2(a2), .RD1(rd1_nb), .RD2(rd2_nb),
    .WE1(we1), .WA1(wa1), .WD1(wd1), .WE2(we2), .WA2(wa2), .WD2(wd2),
    .ResvEn(resv), .ResvReg(rr), .Busy1(busy1_nb), .Busy2(busy2_nb));

  function automatic vec_t mk(input logic w1, input logic [4:0] x1, input logic [31:0] d1,
                              input logic w2, input logic [4:0] x2, input logic [31:0] d2,
                              input logic rv, input logic [4:0] rg,
                              input logic [4:0] p1, input logic [4:0] p2,
                              input logic [31:0] er1, input logic [31:0] er2,
                              input logic eb1, input logic eb2,
                              input logic [31:0] er1nb, input logic eb1nb);
    vec_t v;
    v.we1 = w1; v.wa1 = x1; v.wd1 = d1;
    v.we2 = w2; v.wa2 = x2; v.wd2 = d2;
    v.resv = rv; v.rr = rg; v.a1 = p1; v.a2 = p2;
    v.e_rd1 = er1; v.e_rd2 = er2; v.e_b1 = eb1; v.e_b2 = eb2;
    v.e_rd1_nb = er1nb; v.e_b1_nb = eb1nb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a read port should return given the current model state.
  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (byp && we2 && (wa2 == a)) return wd2;
    if (byp && we1 && (wa1 == a)) return wd1;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (byp && ((we1 && (wa1 == a)) || (we2 && (wa2 == a)))) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'd0;
      mbusy[i] = 1'b0;
    end
  endtask

  // Apply the clock-edge effect of the current inputs: writes in port order
  // (so port 2 lands last), then releases, then the reserve on top.
  task automatic model_update();
    if (we1 && (wa1 != 5'd0)) mreg[wa1] = wd1;
    if (we2 && (wa2 != 5'd0)) mreg[wa2] = wd2;
    if (we1) mbusy[wa1] = 1'b0;
    if (we2) mbusy[wa2] = 1'b0;
    if (resv && (rr != 5'd0)) mbusy[rr] = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rd1"},      rd1,              exp_rd(1'b1, a1));
    check({tag, "_rd2"},      rd2,              exp_rd(1'b1, a2));
    check({tag, "_busy1"},    {31'd0, busy1},    {31'd0, exp_busy(1'b1, a1)});
    check({tag, "_busy2"},    {31'd0, busy2},    {31'd0, exp_busy(1'b1, a2)});
    check({tag, "_rd1_nb"},   rd1_nb,           exp_rd(1'b0, a1));
    check({tag, "_rd2_nb"},   rd2_nb,           exp_rd(1'b0, a2));
    check({tag, "_busy1_nb"}, {31'd0, busy1_nb}, {31'd0, exp_busy(1'b0, a1)});
    check({tag, "_busy2_nb"}, {31'd0, busy2_nb}, {31'd0, exp_busy(1'b0, a2)});
  endtask

  task automatic idle_inputs();
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
    we2 = 1'b0; wa2 = 5'd0; wd2 = 32'd0;
    resv = 1'b0; rr = 5'd0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    tbl[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[1]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd7,
                 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    tbl[2]  = mk(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0, 5'd0, 5'd7, 5'd7,
                 32'h22222222, 32'h22222222, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[3]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd5,
                 32'h22222222, 32'hDEADBEEF, 1'b0, 1'b0, 32'h22222222, 1'b0);
    tbl[4]  = mk(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0,
                 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[5]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[6]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9,
                 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[7]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9,
                 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1);
    tbl[8]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE0009, 1'b0, 5'd0, 5'd9, 5'd9,
                 32'hCAFE0009, 32'hCAFE0009, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[9]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9,
                 32'hCAFE0009, 32'hCAFE0009, 1'b0, 1'b0, 32'hCAFE0009, 1'b0);
    tbl[10] = mk(1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3,
                 32'h33333333, 32'h33333333, 1'b0, 1'b0, 32'd0, 1'b0);
    tbl[11] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9,
                 32'h33333333, 32'hCAFE0009, 1'b1, 1'b0, 32'h33333333, 1'b1);
    tbl[12] = mk(1'b1, 5'd3, 32'h44444444, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3,
                 32'h44444444, 32'h44444444, 1'b0, 1'b0, 32'h33333333, 1'b1);
    tbl[13] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3,
                 32'h44444444, 32'h44444444, 1'b0, 1'b0, 32'h44444444, 1'b0);

    // Power-on reset.
    reset = 1'b1;
    idle_inputs();
    a1 = 5'd0; a2 = 5'd0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Sweep every address on both ports after reset.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      a1 = 5'(a);
      a2 = 5'(31 - a);
      #1;
      check("reset_rd1", rd1, 32'd0);
      check("reset_rd2", rd2, 32'd0);
      check("reset_busy", {30'd0, busy1, busy2}, 32'd0);
      check("reset_nb", {rd1_nb | rd2_nb}, 32'd0);
      check("reset_busy_nb", {30'd0, busy1_nb, busy2_nb}, 32'd0);
    end

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      we2 = tbl[i].we2; wa2 = tbl[i].wa2; wd2 = tbl[i].wd2;
      resv = tbl[i].resv; rr = tbl[i].rr;
      a1 = tbl[i].a1; a2 = tbl[i].a2;
      #1;
      check($sformatf("tbl%0d_rd1", i),    rd1, tbl[i].e_rd1);
      check($sformatf("tbl%0d_rd2", i),    rd2, tbl[i].e_rd2);
      check($sformatf("tbl%0d_busy1", i),  {31'd0, busy1}, {31'd0, tbl[i].e_b1});
      check($sformatf("tbl%0d_busy2", i),  {31'd0, busy2}, {31'd0, tbl[i].e_b2});
      check($sformatf("tbl%0d_rd1_nb", i), rd1_nb, tbl[i].e_rd1_nb);
      check($sformatf("tbl%0d_busy1_nb", i), {31'd0, busy1_nb}, {31'd0, tbl[i].e_b1_nb});
      @(posedge clk);
      model_update();
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      we1  = ($urandom_range(0, 1) == 1);
      wa1  = rand_addr();
      wd1  = $urandom;
      we2  = ($urandom_range(0, 2) == 0);
      wa2  = rand_addr();
      wd2  = $urandom;
      resv = ($urandom_range(0, 2) == 0);
      rr   = rand_addr();
      a1   = rand_addr();
      a2   = ($urandom_range(0, 4) == 0) ? a1 : rand_addr();
      #1;
      check_model("rand");
      @(posedge clk);
      model_update();
    end

    // Asynchronous reset in the middle of a write burst.
    @(negedge clk);
    idle_inputs();
    we1 = 1'b1; wa1 = 5'd10; wd1 = 32'hA5A5A5A5;
    resv = 1'b1; rr = 5'd11;
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle_inputs();
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h5A5A5A5A;
    a1 = 5'd10; a2 = 5'd11;
    #1;
    check("pre_rst_rd1", rd1, 32'hA5A5A5A5);
    check("pre_rst_busy2", {31'd0, busy2}, 32'd1);
    reset = 1'b1;
    #1;
    model_clear();
    check("async_rst_rd1", rd1, 32'd0);
    check("async_rst_busy2", {31'd0, busy2}, 32'd0);
    check("async_rst_rd1_nb", rd1_nb, 32'd0);
    check("async_rst_busy2_nb", {31'd0, busy2_nb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    a1 = 5'd12; a2 = 5'd10;
    #1;
    check("rst_write_ignored", rd1, 32'd0);
    check("rst_rd2", rd2, 32'd0);
    check_model("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
